// File: rtl/ga20_fetch_arbiter_if.sv
// GA20 fetch arbiter bus: channel request/ack side and sample-cache read side.
// slave = arbiter, master = requesters plus cache.
interface ga20_fetch_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 20
);
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_ack;
  logic [7:0]               ch_data;
  logic                     ch_err;
  logic                     mem_rd;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_valid;
  logic [7:0]               mem_dout;
  logic                     busy;

  modport slave (
    input  ch_req, ch_addr, mem_valid, mem_dout,
    output ch_ack, ch_data, ch_err, mem_rd, mem_addr, busy
  );

  modport master (
    output ch_req, ch_addr, mem_valid, mem_dout,
    input  ch_ack, ch_data, ch_err, mem_rd, mem_addr, busy
  );
endinterface

// File: rtl/ga20_fetch_arbiter.sv
// GA20 sample-fetch arbiter: round-robin grant, one cache read in flight,
// one-cycle ack per byte, timeout abort when the cache never answers.
module ga20_fetch_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  ga20_fetch_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_CH);
  localparam logic [9:0] LIM = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic [GW-1:0]     pick;
  logic              found;
  logic [9:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [7:0]        data_q, data_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Two passes: channels above last_grant first, then wrap to the rest.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && bus.ch_req[c] && GW'(c) > last_q) begin
        found = 1'b1;
        pick  = GW'(c);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!found && bus.ch_req[c] && GW'(c) <= last_q) begin
        found = 1'b1;
        pick  = GW'(c);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    data_d  = data_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          last_d  = pick;
          addr_d  = bus.ch_addr[pick*ADDR_W +: ADDR_W];
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        unique case (1'b1)
          bus.mem_valid: begin
            data_d         = bus.mem_dout;
            ack_d[grant_q] = 1'b1;
            state_d        = DONE;
          end
          (cnt_q == LIM): begin
            data_d         = 8'h80;
            err_d          = 1'b1;
            ack_d[grant_q] = 1'b1;
            state_d        = DONE;
          end
          default: cnt_d = cnt_q + 10'd1;
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_CH - 1);
      cnt_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.ch_ack   = ack_q;
  assign bus.ch_data  = data_q;
  assign bus.ch_err   = err_q;
  assign bus.mem_rd   = (state_q == REQ);
  assign bus.mem_addr = addr_q;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_ga20_fetch_arbiter.sv
// Bench for ga20_fetch_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
module tb_ga20_fetch_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 20;
  localparam int TMO = 16;

  logic clk;
  logic reset;

  ga20_fetch_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW)) bus ();

  ga20_fetch_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fdat(logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Reference model: the current transaction is described by who owns the
  // port, how long the cache has been asked, and the pending result.
  bit            model_live = 0;
  int            m_phase;
  int            m_last, m_g, m_wait;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;
  logic [NCH-1:0] m_ack;
  logic          m_err;
  int            fair [NCH];

  always @(posedge clk) begin
    model_live = 1;
    if (reset) begin
      m_phase = 0; m_ack = '0; m_data = '0; m_err = 0;
      m_addr = '0; m_last = NCH - 1; m_wait = 0; m_g = 0;
      for (int i = 0; i < NCH; i++) fair[i] = 0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (!bus.ch_req[i]) fair[i] = 0;
      case (m_phase)
        0: begin
          m_ack = '0; m_err = 0;
          if (|bus.ch_req) begin
            for (int k = NCH; k >= 1; k--)
              if (bus.ch_req[(m_last + k) % NCH]) m_g = (m_last + k) % NCH;
            chk("fairness", 32'(fair[m_g] <= NCH - 1), 1);
            for (int i = 0; i < NCH; i++)
              if (bus.ch_req[i] && i != m_g) fair[i]++;
            fair[m_g] = 0;
            m_addr  = bus.ch_addr[m_g*AW +: AW];
            m_last  = m_g;
            m_wait  = 0;
            m_phase = 1;
          end
        end
        1: begin
          if (bus.mem_valid) begin
            m_data = bus.mem_dout; m_err = 0;
            m_ack = NCH'(1) << m_g; m_phase = 2;
          end else if (m_wait + 1 == TMO) begin
            m_data = 8'h80; m_err = 1;
            m_ack = NCH'(1) << m_g; m_phase = 2;
          end else m_wait++;
        end
        default: begin
          m_ack = '0; m_err = 0; m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("ch_ack", 32'(bus.ch_ack), 32'(m_ack));
      chk("ch_data", 32'(bus.ch_data), 32'(m_data));
      chk("ch_err", 32'(bus.ch_err), 32'(m_err));
      chk("mem_rd", 32'(bus.mem_rd), 32'(m_phase == 1));
      chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      chk("busy", 32'(bus.busy), 32'(m_phase != 0));
    end
  end

  // Stimulus state shared by the requesters and the cache responder.
  int cyc = 0;
  logic [NCH-1:0] rereq = '0;
  bit  cache_auto = 1;
  bit  rand_cache = 0;
  int  cur_delay = 0;
  int  dout_fixed = -1;
  int  rd_age = 0;
  int  rd_rise = 0;
  int  last_valid = 0;
  int  ack_ch[$];
  int  ack_cyc[$];
  logic [7:0] ack_dat[$];
  logic ack_err[$];

  task automatic tick();
    logic v;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.ch_ack != '0) begin
      for (int i = 0; i < NCH; i++)
        if (bus.ch_ack[i]) begin
          ack_ch.push_back(i);
          if (rereq[i]) bus.ch_addr[i*AW +: AW] = AW'($urandom);
          else bus.ch_req[i] = 1'b0;
        end
      ack_cyc.push_back(cyc);
      ack_dat.push_back(bus.ch_data);
      ack_err.push_back(bus.ch_err);
    end
    if (bus.mem_rd) begin
      rd_age++;
      if (rd_age == 1) begin
        rd_rise = cyc;
        if (rand_cache)
          cur_delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
      end
    end else rd_age = 0;
    if (cache_auto) begin
      v = bus.mem_rd && cur_delay >= 0 && rd_age > cur_delay;
      if (v) last_valid = cyc;
      if (!bus.mem_rd && rand_cache && $urandom_range(0, 5) == 0) v = 1'b1;
      bus.mem_valid = v;
      if (v) bus.mem_dout = (dout_fixed >= 0) ? 8'(dout_fixed) : fdat(bus.mem_addr);
      else bus.mem_dout = 8'($urandom);
    end
  endtask

  task automatic clear_log();
    ack_ch.delete(); ack_cyc.delete(); ack_dat.delete(); ack_err.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ch_req = '0;
    rereq = '0;
    tick();
    reset = 1'b0;
    clear_log();
  endtask

  task automatic wait_acks(int n, int budget);
    int t = 0;
    while (ack_ch.size() < n && t < budget) begin
      tick();
      t++;
    end
    chk("ack_count_within_budget", 32'(ack_ch.size()), 32'(n));
  endtask

  logic [AW-1:0] a [NCH];

  initial begin
    reset = 1'b1;
    bus.ch_req = '0;
    bus.ch_addr = '0;
    bus.mem_valid = 1'b0;
    bus.mem_dout = '0;
    tick();

    // T1: single request, cache answers on the 4th mem_rd cycle
    do_reset();
    chk("rst_ack", 32'(bus.ch_ack), 0);
    chk("rst_data", 32'(bus.ch_data), 0);
    chk("rst_err", 32'(bus.ch_err), 0);
    chk("rst_rd", 32'(bus.mem_rd), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    cache_auto = 1; rand_cache = 0; cur_delay = 3; dout_fixed = 8'h5A;
    bus.ch_addr[0 +: AW] = 20'h12345;
    bus.ch_req = 4'b0001;
    tick();
    chk("t1_mem_rd", 32'(bus.mem_rd), 1);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'h12345);
    wait_acks(1, 20);
    repeat (3) tick();
    chk("t1_one_ack", 32'(ack_ch.size()), 1);
    chk("t1_ch", 32'(ack_ch[0]), 0);
    chk("t1_data", 32'(ack_dat[0]), 32'h5A);
    chk("t1_err", 32'(ack_err[0]), 0);
    chk("t1_valid_to_ack", 32'(ack_cyc[0] - last_valid), 1);
    chk("t1_rd_to_ack", 32'(ack_cyc[0] - rd_rise), 4);

    // T2: four simultaneous requests, immediate cache
    do_reset();
    cur_delay = 0; dout_fixed = -1;
    for (int i = 0; i < NCH; i++) begin
      a[i] = AW'($urandom);
      bus.ch_addr[i*AW +: AW] = a[i];
    end
    bus.ch_req = 4'b1111;
    wait_acks(4, 40);
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", 32'(ack_ch[k]), 32'(k));
      chk("t2_data", 32'(ack_dat[k]), 32'(fdat(a[k])));
      if (k > 0) chk("t2_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), 3);
    end

    // T3: channels 1 and 3 re-request after every ack
    do_reset();
    cur_delay = 1;
    rereq = 4'b1010;
    bus.ch_req = 4'b1010;
    wait_acks(8, 80);
    rereq = '0;
    repeat (15) tick();
    for (int k = 0; k < 8; k++)
      chk("t3_alternate", 32'(ack_ch[k]), (k % 2 == 0) ? 32'd1 : 32'd3);

    // T4: cache never answers, then a normal transaction
    do_reset();
    cur_delay = -1;
    a[2] = AW'($urandom);
    bus.ch_addr[2*AW +: AW] = a[2];
    bus.ch_req = 4'b0100;
    wait_acks(1, 40);
    chk("t4_ch", 32'(ack_ch[0]), 2);
    chk("t4_err", 32'(ack_err[0]), 1);
    chk("t4_data", 32'(ack_dat[0]), 32'h80);
    chk("t4_rd_to_ack", 32'(ack_cyc[0] - rd_rise), TMO);
    cur_delay = 1;
    tick();
    bus.ch_req = 4'b0100;
    wait_acks(2, 20);
    chk("t4_next_err", 32'(ack_err[1]), 0);
    chk("t4_next_data", 32'(ack_dat[1]), 32'(fdat(a[2])));

    // T5: reset lands mid-transaction, late valid must be ignored
    do_reset();
    cur_delay = -1;
    bus.ch_req = 4'b0001;
    repeat (3) tick();
    chk("t5_in_req", 32'(bus.mem_rd), 1);
    reset = 1'b1;
    bus.ch_req = '0;
    tick();
    reset = 1'b0;
    chk("t5_rd", 32'(bus.mem_rd), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_data", 32'(bus.ch_data), 0);
    cache_auto = 0;
    bus.mem_valid = 1'b1;
    bus.mem_dout = 8'h77;
    tick();
    bus.mem_valid = 1'b0;
    tick();
    chk("t5_no_ack", 32'(ack_ch.size()), 0);
    cache_auto = 1; cur_delay = 0;
    for (int i = 0; i < NCH; i++) begin
      a[i] = AW'($urandom);
      bus.ch_addr[i*AW +: AW] = a[i];
    end
    bus.ch_req = 4'b1111;
    wait_acks(4, 40);
    chk("t5_first_grant", 32'(ack_ch[0]), 0);

    // T6: spurious valid while idle
    tick();
    cache_auto = 0;
    bus.mem_valid = 1'b1;
    bus.mem_dout = 8'hFF;
    tick();
    chk("t6_busy", 32'(bus.busy), 0);
    tick();
    bus.mem_valid = 1'b0;
    chk("t6_no_ack", 32'(ack_ch.size()), 4);
    chk("t6_data_held", 32'(bus.ch_data), 32'(fdat(a[3])));
    cache_auto = 1;

    // Randomized traffic with random cache latency, timeouts and resets
    do_reset();
    rand_cache = 1;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!bus.ch_req[i] && $urandom_range(0, 3) == 0) begin
          bus.ch_addr[i*AW +: AW] = AW'($urandom);
          bus.ch_req[i] = 1'b1;
        end else if (bus.ch_req[i] && $urandom_range(0, 49) == 0)
          bus.ch_req[i] = 1'b0;
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
